// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: FSM state type and default parameters shared by the
// fetch PC generator and its return stack.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } pc_state_e;

  localparam int unsigned     PC_ADDR_W    = 64;
  localparam int unsigned     PC_INC       = 4;
  localparam longint unsigned PC_RESET_VEC = 0;
  localparam int unsigned     PC_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push while full overwrites
// the oldest entry, and push+pop together replaces the top entry.
module pc_ras
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = PC_ADDR_W,
  parameter int unsigned DEPTH  = PC_RAS_DEPTH
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     top_idx, wr_idx;
  logic [CW-1:0]     cnt_q, cnt_d;

  assign top_idx = ptr_q - PW'(1);
  assign wr_idx  = pop_i ? top_idx : ptr_q;
  assign top_o   = mem_q[top_idx];
  assign empty_o = (cnt_q == '0);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        ptr_d = ptr_q + PW'(1);
        if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
      end
      2'b01: begin
        if (cnt_q != '0) begin
          ptr_d = top_idx;
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(negedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Contents are only meaningful below the count, so no reset is needed.
  always_ff @(negedge Clock) begin
    if (push_i) mem_q[wr_idx] <= push_data_i;
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with redirect, halt and an
// optional return-address stack enabled by PC_RAS_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W    = PC_ADDR_W,
  parameter int unsigned       INC       = PC_INC,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
  parameter int unsigned       RAS_DEPTH = PC_RAS_DEPTH
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Hit,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectAddr,
  input  logic              Halt,
  input  logic              Call,
  input  logic              Ret,
  output logic [ADDR_W-1:0] Address,
  output logic              Valid,
  output logic              RasEmpty
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] seq_addr;

  assign seq_addr = addr_q + ADDR_W'(INC);

`ifdef PC_RAS_EN
  logic              ras_push, ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;

  pc_ras #(
    .ADDR_W(ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .push_i     (ras_push),
    .pop_i      (ras_pop),
    .push_data_i(seq_addr),
    .top_o      (ras_top),
    .empty_o    (ras_empty)
  );

  assign RasEmpty = ras_empty;
`else
  logic unused_ras;
  assign unused_ras = ^{Call, Ret};
  assign RasEmpty   = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
`ifdef PC_RAS_EN
    ras_push = 1'b0;
    ras_pop  = 1'b0;
`endif
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (Redirect) begin
          addr_d = RedirectAddr;
        end else if (Halt) begin
          state_d = HALTED;
        end else if (Hit) begin
          addr_d = seq_addr;
`ifdef PC_RAS_EN
          ras_push = Call;
          // Empty stack: a return falls back to the sequential address.
          if (Ret && !ras_empty) begin
            addr_d  = ras_top;
            ras_pop = 1'b1;
          end
`endif
        end
      end
      HALTED: begin
        if (Redirect) begin
          addr_d  = RedirectAddr;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(negedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= BOOT;
      addr_q  <= RESET_VEC;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign Address = addr_q;
  assign Valid   = (state_q == RUN);

endmodule
